// File: rtl/countdown_mmss.sv
// countdown_mmss: BCD MM:SS countdown timer driven by the shared 1 Hz ena strobe.
// A value is loaded in BCD, counted down one second per tick while running, and
// expiry at 00:00 is flagged with a level (done) and a one-cycle pulse (expired).
// All outputs come straight from flops so the display path sees clean values.

module countdown_mmss #(
  parameter logic [7:0] MM_MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       expired_q, expired_d;
  logic       load_err_q, load_err_d;

  // ------------------------------------------------------------------
  // Load validation: each of the four BCD nibbles must be a decimal digit,
  // and the two bytes must respect their range limits.
  // ------------------------------------------------------------------
  logic [15:0] load_word;
  logic [3:0]  nib_ok;
  logic        load_ok;

  assign load_word = {load_mm, load_ss};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib_check
      assign nib_ok[gi] = (load_word[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign load_ok = (&nib_ok) && (load_ss <= 8'h59) && (load_mm <= MM_MAX);

  // ------------------------------------------------------------------
  // Value classification used by start and expiry decisions.
  // ------------------------------------------------------------------
  logic is_zero;
  logic is_one;

  assign is_zero = (mm_q == 8'h00) && (ss_q == 8'h00);
  assign is_one  = (mm_q == 8'h00) && (ss_q == 8'h01);

  // ------------------------------------------------------------------
  // Digit-wise BCD decrement by one second. Each digit wraps to its own
  // maximum (9 or 5) and borrows from the next; no binary arithmetic on
  // the full value, so nibbles never pass through A-F.
  // ------------------------------------------------------------------
  logic [3:0] ss_u_dec, ss_t_dec, mm_u_dec, mm_t_dec;
  logic       borrow_ss_u, borrow_ss_t, borrow_mm_u;

  // Borrow chain from seconds units up to minutes tens.
  always_comb begin
    ss_u_dec    = ss_q[3:0];
    ss_t_dec    = ss_q[7:4];
    mm_u_dec    = mm_q[3:0];
    mm_t_dec    = mm_q[7:4];
    borrow_ss_u = 1'b0;
    borrow_ss_t = 1'b0;
    borrow_mm_u = 1'b0;

    if (ss_q[3:0] != 4'd0) begin
      ss_u_dec = ss_q[3:0] - 4'd1;
    end else begin
      ss_u_dec    = 4'd9;
      borrow_ss_u = 1'b1;
    end

    if (borrow_ss_u) begin
      if (ss_q[7:4] != 4'd0) begin
        ss_t_dec = ss_q[7:4] - 4'd1;
      end else begin
        ss_t_dec    = 4'd5;
        borrow_ss_t = 1'b1;
      end
    end

    if (borrow_ss_t) begin
      if (mm_q[3:0] != 4'd0) begin
        mm_u_dec = mm_q[3:0] - 4'd1;
      end else begin
        mm_u_dec    = 4'd9;
        borrow_mm_u = 1'b1;
      end
    end

    // Minutes tens is non-zero whenever a borrow reaches it, because the
    // counter never decrements from 00:00; the guard keeps it a digit anyway.
    if (borrow_mm_u && (mm_q[7:4] != 4'd0)) begin
      mm_t_dec = mm_q[7:4] - 4'd1;
    end
  end

  // ------------------------------------------------------------------
  // Next-state decision, priority load > pause > start > ena. A load in
  // RUN is treated as absent, so lower-priority controls still apply.
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    expired_d  = 1'b0;
    load_err_d = load_err_q;

    if (load && (state_q != ST_RUN)) begin
      if (load_ok) begin
        mm_d       = load_mm;
        ss_d       = load_ss;
        state_d    = ST_IDLE;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause && (state_q == ST_RUN)) begin
      // Any ena on this cycle is dropped: pausing wins.
      state_d = ST_PAUSED;
    end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      if (!is_zero) begin
        state_d = ST_RUN;
      end
    end else if (ena && (state_q == ST_RUN) && !is_zero) begin
      mm_d = {mm_t_dec, mm_u_dec};
      ss_d = {ss_t_dec, ss_u_dec};
      if (is_one) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end
    end
  end

  // Status flags are registered from the next state so they change on the
  // same edge as the state itself.
  assign running_d = (state_d == ST_RUN);
  assign done_d    = (state_d == ST_DONE);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      running_q  <= running_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
      load_err_q <= load_err_d;
    end
  end

  assign mm       = mm_q;
  assign ss       = ss_q;
  assign running  = running_q;
  assign done     = done_q;
  assign expired  = expired_q;
  assign load_err = load_err_q;

endmodule
